fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: NUM_REQ, 4, number of requesters; DATA_WIDTH, 8, word width; ADDR_WIDTH, 5, FIFO address width (DEPTH = 2**ADDR_WIDTH = 32); MAX_BURST, 4, max beats per grant.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
 - clk  in  1  single clock; all state on rising edge.
 - rst_n  in  1  asynchronous active-low reset.
 - req  in  NUM_REQ  per-requester beat valid.
 - req_last  in  NUM_REQ  final beat of requester burst.
 - req_data  in  NUM_REQ*DATA_WIDTH  requester i data in slice [i*DATA_WIDTH +: DATA_WIDTH].
 - gnt  out  NUM_REQ  one-hot owner indication.
 - fifo_wr_en  out  1  write strobe to FIFO.
 - fifo_wr_data  out  DATA_WIDTH  write data to FIFO.
 - fifo_rd_en  in  1  FIFO read strobe from consumer.
 - fifo_count  out  ADDR_WIDTH+1  tracked occupancy, 0..DEPTH.
 - fifo_full  out  1  fifo_count == DEPTH.
 - fifo_empty  out  1  fifo_count == 0.
REQ-003 Clock and reset SHALL be: one clock, clk; reset rst_n, asynchronous, active-low.

Function
REQ-004 FSM SHALL have two states: IDLE, BURST.
REQ-005 In IDLE with any req bit high, the next state SHALL be BURST; owner = first requester with req high, searching round-robin from (last_owner+1) mod NUM_REQ.
REQ-006 Arbitration SHALL take one cycle: gnt is 0 in IDLE and is set to the one-hot owner only in BURST.
REQ-007 A beat SHALL be accepted in the cycle where state==BURST && req[owner] && !fifo_full; fifo_wr_en SHALL be combinationally high exactly then.
REQ-008 fifo_wr_data SHALL equal the req_data slice of owner (combinational) and SHALL be 0 when fifo_wr_en is low.
REQ-009 When fifo_full is high in BURST, the block SHALL stall in BURST with gnt held, and the beat counter SHALL NOT advance.
REQ-010 BURST SHALL exit to IDLE after an accepted beat with req_last[owner]=1, or after the accepted beat that makes beat count == MAX_BURST, or in any cycle where req[owner]=0.
REQ-011 last_owner SHALL update to owner on IDLE->BURST; the beat counter SHALL clear on entering BURST.
REQ-012 fifo_count SHALL increment on a write-only cycle, decrement on an accepted read (fifo_rd_en && !fifo_empty), and stay unchanged when both occur.
REQ-013 A read while empty SHALL be ignored, so the count never underflows; a write is blocked while full, so the count never exceeds DEPTH.
REQ-014 Full/empty SHALL be decoded from the registered count with no lookahead: a write is refused in a full cycle even if a read occurs in the same cycle.
REQ-015 req or req_last on non-owners SHALL be ignored during BURST.

Reset
REQ-016 rst_n low SHALL force, asynchronously: state=IDLE, fifo_count=0, beat counter=0, and last_owner=NUM_REQ-1, so requester 0 has first priority.
REQ-017 While in reset, outputs SHALL be: gnt=0, fifo_wr_en=0, fifo_wr_data=0, fifo_empty=1, fifo_full=0.
REQ-018 Reset asserted mid-burst SHALL discard the burst; no partial-state recovery is required.

Structure
REQ-019 The shared header/package fifo_defs SHALL hold the state encodings (IDLE=0, BURST=1) and the DEPTH derivation.
REQ-020 The round-robin pick SHALL be a combinational sub-module, rr_pick (inputs req and last_owner; output one-hot choice), instantiated once.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
 - Reset then req=4'b0001 with 3 beats, last on beat 3 -> gnt=0001 from cycle 2; three fifo_wr_en pulses; fifo_count=3; return to IDLE.
 - req=4'b1111 held, req_last never asserted -> grants 0001,0010,0100,1000,0001 in turn; 4 beats each; one idle cycle between grants.
 - 32 writes with no reads -> fifo_full=1, fifo_count=32; further beats stall with gnt held; one read -> count=31, write resumes the following cycle.
 - Full with write and read in the same cycle -> write refused, count 32->31.
 - fifo_rd_en while empty -> fifo_count stays 0, fifo_empty stays 1.
 - rst_n pulsed low mid-burst at count=5 -> immediately gnt=0, fifo_count=0; after release, requester 0 wins first.

Source files
------------

// File: rtl/fifo_defs.sv
// Shared definitions for the FIFO write arbiter:
// FSM encodings and FIFO geometry helpers.
package fifo_defs;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin requester pick, combinational.
// Search starts one past the previous owner.
module rr_pick
    import fifo_defs::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_owner,
    output logic [NUM_REQ-1:0] choice
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        choice = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IW'((int'(last_owner) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                choice[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst write arbiter in front of a FIFO whose
// occupancy is tracked locally from write/read strobes.
module fifo_wr_arbiter
    import fifo_defs::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    input  logic                          fifo_rd_en,
    output logic [ADDR_WIDTH:0]           fifo_count,
    output logic                          fifo_full,
    output logic                          fifo_empty
);

    localparam int DEPTH = depth_of(ADDR_WIDTH);
    localparam int IW    = idx_w(NUM_REQ);
    localparam int BW    = $clog2(MAX_BURST + 1);
    localparam int CW    = ADDR_WIDTH + 1;

    localparam logic [IW-1:0] RST_OWNER = IW'(NUM_REQ - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   last_owner;
    logic [BW-1:0]   beat_cnt;
    logic [BW-1:0]   beat_nxt;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic [NUM_REQ-1:0] pick;
    logic [IW-1:0]   pick_idx;
    logic            owner_load;
    logic            own_req;
    logic            own_last;
    logic            beat_max;
    logic            wr_ok;
    logic            rd_ok;
    logic [DATA_WIDTH-1:0] own_data;

    rr_pick #(
        .NUM_REQ    (NUM_REQ),
        .IW         (IW)
    ) u_rr_pick (
        .req        (req),
        .last_owner (last_owner),
        .choice     (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) pick_idx = pick_idx | IW'(i);
        end
    end

    // In BURST the owner is always the last requester loaded.
    assign own_req  = req[last_owner];
    assign own_last = req_last[last_owner];
    assign own_data = req_data[last_owner*DATA_WIDTH +: DATA_WIDTH];
    assign beat_max = (beat_cnt == LAST_BEAT);

    // Full/empty come straight from the registered count.
    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign fifo_count = count;

    assign wr_ok = (state == BURST) && own_req && !fifo_full;
    assign rd_ok = fifo_rd_en && !fifo_empty;

    assign fifo_wr_en   = wr_ok;
    assign fifo_wr_data = wr_ok ? own_data : '0;

    always_comb begin
        gnt = '0;
        if (state == BURST) gnt[last_owner] = 1'b1;
    end

    always_comb begin
        state_nxt  = state;
        beat_nxt   = beat_cnt;
        owner_load = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt  = BURST;
                    beat_nxt   = '0;
                    owner_load = 1'b1;
                end
            end
            BURST: begin
                if (!own_req) begin
                    state_nxt = IDLE;
                end else if (wr_ok) begin
                    beat_nxt = beat_cnt + 1'b1;
                    if (own_last || beat_max) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        count_nxt = count;
        unique case (1'b1)
            (wr_ok && !rd_ok): count_nxt = count + 1'b1;
            (rd_ok && !wr_ok): count_nxt = count - 1'b1;
            default:           count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_owner <= RST_OWNER;
            beat_cnt   <= '0;
            count      <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_nxt;
            count    <= count_nxt;
            if (owner_load) last_owner <= pick_idx;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: cycle table, scoreboarded
// write data, and directed full/reset sequences.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int AW = 5;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req;
    logic [NR-1:0]     req_last;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     gnt;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_wr_data;
    logic              fifo_rd_en;
    logic [AW:0]       fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ      (NR),
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .MAX_BURST    (MB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_last     (req_last),
        .req_data     (req_data),
        .gnt          (gnt),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_count   (fifo_count),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] sb[$];
    int bcnt[NR];

    logic [NR-1:0] s_gnt;
    logic          s_wr;
    logic          s_full;
    logic          s_emp;
    logic [AW:0]   s_cnt;

    typedef struct {
        logic [3:0] req;
        logic [3:0] last;
        logic       rd;
        logic [3:0] gnt;
        logic       wr;
        logic [5:0] cnt;
        logic       emp;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [DW-1:0] beat_data(input int id, input int b);
        return DW'(id * 64 + b);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic build_data();
        for (int i = 0; i < NR; i++)
            req_data[i*DW +: DW] = beat_data(i, bcnt[i]);
    endtask

    // One clock: drive at edge+1, sample at edge+3, advance.
    task automatic cyc(input logic [3:0] r, input logic [3:0] l,
                       input logic rd);
        req        = r;
        req_last   = l;
        fifo_rd_en = rd;
        build_data();
        #2;
        s_gnt  = gnt;
        s_wr   = fifo_wr_en;
        s_full = fifo_full;
        s_emp  = fifo_empty;
        s_cnt  = fifo_count;
        chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
        if (!fifo_wr_en) chk("wr_data_idle", 32'(fifo_wr_data), 32'd0);
        if (fifo_wr_en) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_extra: got write %0h expected none",
                         fifo_wr_data);
            end else begin
                chk("sb_data", 32'(fifo_wr_data), 32'(sb.pop_front()));
            end
        end
        @(posedge clk);
        #1;
        if (s_wr)
            for (int i = 0; i < NR; i++)
                if (s_gnt[i]) bcnt[i]++;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_wr_data", 32'(fifo_wr_data), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_full", 32'(fifo_full), 32'd0);
        sb.delete();
        for (int i = 0; i < NR; i++) bcnt[i] = 0;
        req        = '0;
        req_last   = '0;
        fifo_rd_en = 1'b0;
        build_data();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic sb_drain(input string nm);
        chk(nm, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        req        = '0;
        req_last   = '0;
        fifo_rd_en = 1'b0;
        for (int i = 0; i < NR; i++) bcnt[i] = 0;
        build_data();

        tbl[0]  = '{4'h1, 4'h0, 1'b0, 4'h0, 1'b0, 6'd0, 1'b1};
        tbl[1]  = '{4'h1, 4'h0, 1'b0, 4'h1, 1'b1, 6'd0, 1'b1};
        tbl[2]  = '{4'h1, 4'h0, 1'b0, 4'h1, 1'b1, 6'd1, 1'b0};
        tbl[3]  = '{4'h1, 4'h1, 1'b0, 4'h1, 1'b1, 6'd2, 1'b0};
        tbl[4]  = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 6'd3, 1'b0};
        tbl[5]  = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 6'd3, 1'b0};
        tbl[6]  = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 6'd3, 1'b0};
        tbl[7]  = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 6'd2, 1'b0};
        tbl[8]  = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 6'd1, 1'b0};
        tbl[9]  = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 6'd0, 1'b1};
        tbl[10] = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 6'd0, 1'b1};
        tbl[11] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 6'd0, 1'b1};

        @(posedge clk);
        #1;
        do_reset();

        // Single 3-beat burst, then drain and over-read.
        for (int b = 0; b < 3; b++) sb.push_back(beat_data(0, b));
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].req, tbl[i].last, tbl[i].rd);
            chk($sformatf("t%0d_gnt", i), 32'(s_gnt), 32'(tbl[i].gnt));
            chk($sformatf("t%0d_wr", i), 32'(s_wr), 32'(tbl[i].wr));
            chk($sformatf("t%0d_cnt", i), 32'(s_cnt), 32'(tbl[i].cnt));
            chk($sformatf("t%0d_emp", i), 32'(s_emp), 32'(tbl[i].emp));
        end
        sb_drain("t_drain");

        // All requesters held, no last: round-robin, 4 beats each.
        do_reset();
        for (int g = 0; g < 5; g++) begin
            for (int b = 0; b < MB; b++)
                sb.push_back(beat_data(g % NR, (g / NR) * MB + b));
            cyc(4'hF, 4'h0, 1'b0);
            chk($sformatf("rr%0d_idle_gnt", g), 32'(s_gnt), 32'd0);
            chk($sformatf("rr%0d_idle_wr", g), 32'(s_wr), 32'd0);
            for (int b = 0; b < MB; b++) begin
                cyc(4'hF, 4'h0, 1'b0);
                chk($sformatf("rr%0d_gnt", g), 32'(s_gnt),
                    32'(1 << (g % NR)));
                chk($sformatf("rr%0d_wr", g), 32'(s_wr), 32'd1);
            end
        end
        cyc(4'h0, 4'h0, 1'b0);
        chk("rr_cnt", 32'(s_cnt), 32'd20);
        sb_drain("rr_drain");

        // Fill to 32, stall on full, simultaneous write+read refused.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            for (int b = 0; b < MB; b++) sb.push_back(beat_data(0, k * MB + b));
            cyc(4'h1, 4'h0, 1'b0);
            chk("fill_idle_gnt", 32'(s_gnt), 32'd0);
            for (int b = 0; b < MB; b++) begin
                cyc(4'h1, 4'h0, 1'b0);
                chk("fill_wr", 32'(s_wr), 32'd1);
            end
        end
        cyc(4'h1, 4'h0, 1'b0);
        chk("full_cnt", 32'(s_cnt), 32'd32);
        chk("full_flag", 32'(s_full), 32'd1);
        for (int s = 0; s < 3; s++) begin
            cyc(4'h1, 4'h0, 1'b0);
            chk("stall_gnt", 32'(s_gnt), 32'h1);
            chk("stall_wr", 32'(s_wr), 32'd0);
            chk("stall_cnt", 32'(s_cnt), 32'd32);
        end
        sb.push_back(beat_data(0, 32));
        cyc(4'h1, 4'h0, 1'b1);
        chk("full_rw_wr", 32'(s_wr), 32'd0);
        chk("full_rw_cnt", 32'(s_cnt), 32'd32);
        cyc(4'h1, 4'h0, 1'b0);
        chk("resume_cnt", 32'(s_cnt), 32'd31);
        chk("resume_full", 32'(s_full), 32'd0);
        chk("resume_wr", 32'(s_wr), 32'd1);
        cyc(4'h1, 4'h0, 1'b0);
        chk("refull_cnt", 32'(s_cnt), 32'd32);
        chk("refull_wr", 32'(s_wr), 32'd0);
        chk("refull_gnt", 32'(s_gnt), 32'h1);
        cyc(4'h0, 4'h0, 1'b0);
        sb_drain("full_drain");

        // Reset asserted mid-burst at count 5.
        do_reset();
        for (int b = 0; b < MB; b++) sb.push_back(beat_data(0, b));
        sb.push_back(beat_data(1, 0));
        for (int c = 0; c < 7; c++) cyc(4'hF, 4'h0, 1'b0);
        req = 4'hF;
        #1;
        chk("pre_rst_cnt", 32'(fifo_count), 32'd5);
        chk("pre_rst_gnt", 32'(gnt), 32'h2);
        sb_drain("pre_rst_drain");
        do_reset();
        sb.push_back(beat_data(0, 0));
        cyc(4'hF, 4'h0, 1'b0);
        chk("post_rst_idle", 32'(s_gnt), 32'd0);
        cyc(4'hF, 4'h0, 1'b0);
        chk("post_rst_gnt", 32'(s_gnt), 32'h1);
        chk("post_rst_wr", 32'(s_wr), 32'd1);
        cyc(4'h0, 4'h0, 1'b0);
        sb_drain("post_rst_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
